// File: rtl/sha3_byte_padder.sv
// sha3_byte_padder: packs a byte stream into rate blocks with SHA-3 padding.
// Each block is held on out/out_ready until the permutation acks it.
module sha3_byte_padder #(
  parameter int         RATE_BYTES = 72,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    byte_last,
  output logic                    byte_ready,
  output logic [8*RATE_BYTES-1:0] out,
  output logic                    out_ready,
  output logic                    last_block,
  input  logic                    ack
);

  localparam int W  = 8 * RATE_BYTES;
  localparam int CW = $clog2(RATE_BYTES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RATE_BYTES);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_out;
  logic          r_out_ready;
  logic          r_byte_ready;
  logic          r_last;
  logic          r_pad_pending;

  logic          w_take;
  logic          w_end;
  logic [CW-1:0] w_c;
  logic [W-1:0]  w_buf;
  logic [W-1:0]  w_pbuf;
  logic [W-1:0]  w_pad;

  // Handshake decode; r_byte_ready is only ever high in FILL.
  always_comb begin
    w_take = r_byte_ready & byte_valid;
    w_end  = r_byte_ready & byte_last;
    w_c    = r_count + {{(CW-1){1'b0}}, w_take};
  end

  // Block with the incoming byte written at the current fill position.
  always_comb begin
    w_buf = r_out;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (w_take && CW'(k) == r_count)
        w_buf[W-1-8*k -: 8] = byte_in;
    end
  end

  // Same block with in-place padding: DOMAIN at c, 0x80 ORed into last byte.
  always_comb begin
    w_pbuf = w_buf;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (CW'(k) == w_c)
        w_pbuf[W-1-8*k -: 8] = w_pbuf[W-1-8*k -: 8] ^ DOMAIN;
    end
    w_pbuf[7:0] = w_pbuf[7:0] | 8'h80;
  end

  // Padding-only block used when the message ended exactly on a block edge.
  always_comb begin
    w_pad            = '0;
    w_pad[W-1 -: 8]  = DOMAIN;
    w_pad[7:0]       = w_pad[7:0] | 8'h80;
  end

  // Fill / hold state machine; all outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FILL;
      r_count       <= '0;
      r_out         <= '0;
      r_out_ready   <= 1'b0;
      r_byte_ready  <= 1'b0;
      r_last        <= 1'b0;
      r_pad_pending <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_take || w_end) begin
            r_count <= w_c;
            r_out   <= w_buf;
          end
          if (w_end) begin
            r_state      <= S_FULL;
            r_out_ready  <= 1'b1;
            r_byte_ready <= 1'b0;
            if (w_c < FULL_CNT) begin
              r_out  <= w_pbuf;
              r_last <= 1'b1;
            end else begin
              r_pad_pending <= 1'b1;
              r_last        <= 1'b0;
            end
          end else if (w_c == FULL_CNT) begin
            r_state      <= S_FULL;
            r_out_ready  <= 1'b1;
            r_byte_ready <= 1'b0;
            r_last       <= 1'b0;
          end else begin
            r_byte_ready <= 1'b1;
          end
        end
        S_FULL: begin
          if (r_out_ready && ack) begin
            r_count     <= '0;
            r_out_ready <= 1'b0;
            if (r_pad_pending) begin
              r_out         <= w_pad;
              r_last        <= 1'b1;
              r_pad_pending <= 1'b0;
            end else begin
              r_out        <= '0;
              r_last       <= 1'b0;
              r_state      <= S_FILL;
              r_byte_ready <= 1'b1;
            end
          end else if (!r_out_ready) begin
            r_out_ready <= 1'b1;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign out        = r_out;
  assign out_ready  = r_out_ready;
  assign last_block = r_last;

endmodule
